id_ex_stage: RTL

- ID/EX pipeline register and operand-delivery stage that directly feeds the execute ALU.
- Latches decoded fields from ID and drives the ALU funct, op1 and op2 inputs, with forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, requests an ID stall, and inserts bubbles.
- Honours branch flush and the backend-wide hold.

---
 rtl/id_ex_stage_pkg.sv | 34 +++
 rtl/id_ex_stage_fwd_unit.sv | 63 ++++++
 rtl/id_ex_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage_pkg
//  Purpose  : Shared definitions for the ID/EX operand-delivery stage:
//             datapath widths, ALU operation encodings and forwarding-select
//             codes.
//  Revision : 1.0  initial release
// ============================================================================
package id_ex_stage_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   // Existing 4-bit ALU operation set; code 0 doubles as the bubble/reset op.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_funct_e;

   // Operand source selects used by the forwarding network.
   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_EXM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage_fwd_unit
//  Purpose  : Per-operand forwarding select. Picks the EX/MEM result, the
//             MEM/WB writeback value or the registered regfile data for one
//             source register. EX/MEM has priority; x0 is never forwarded.
//  Ports    : i_rs            source register index held in ID/EX
//             i_reg_data      registered regfile read data
//             i_exm_*         EX/MEM destination, write enable, result
//             i_wb_*          MEM/WB destination, write enable, data
//             o_data          operand value delivered to EX
//  Config   : FWD_EN defined   -> forwarding network active
//             FWD_EN undefined -> o_data is always the registered data
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage_fwd_unit
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_rs,
   input  logic [XLEN-1:0]   i_reg_data,
   input  logic [REG_AW-1:0] i_exm_rd,
   input  logic              i_exm_we,
   input  logic [XLEN-1:0]   i_exm_result,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_we,
   input  logic [XLEN-1:0]   i_wb_data,
   output logic [XLEN-1:0]   o_data
);

`ifdef FWD_EN
   logic [1:0] w_sel;

   always_comb begin
      w_sel = FWD_REG;
      if (i_rs != '0) begin
         if (i_exm_we && (i_exm_rd == i_rs))
            w_sel = FWD_EXM;
         else if (i_wb_we && (i_wb_rd == i_rs))
            w_sel = FWD_WB;
      end
   end

   always_comb begin
      o_data = i_reg_data;
      case (w_sel)
         FWD_EXM: o_data = i_exm_result;
         FWD_WB:  o_data = i_wb_data;
         default: o_data = i_reg_data;
      endcase
   end
`else
   // No forwarding: stalls in the parent cover every RAW hazard.
   logic w_unused;
   assign w_unused = ^{i_rs, i_exm_rd, i_exm_we, i_exm_result,
                       i_wb_rd, i_wb_we, i_wb_data};
   assign o_data   = i_reg_data;
`endif

endmodule : id_ex_stage_fwd_unit
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register and operand delivery to the EX ALU.
//             Latches decoded fields, forwards from EX/MEM and MEM/WB,
//             detects load-use hazards (stall ID + insert one bubble) and
//             honours branch flush and the backend hold.
//  Ports    : clk, rst_n          clock, synchronous active-low reset
//             i_id_*              decoded instruction fields from ID
//             i_flush, i_hold     squash entering instruction / freeze
//             i_exm_*, i_wb_*     downstream destinations and values
//             o_ex_*              registered controls, PC and rd
//             o_alu_*             ALU funct and operands
//             o_ex_store_data     forwarded rs2 for stores
//             o_id_stall          ID/IF must hold their instruction
//  Config   : FWD_EN defined   -> forwarding, stall only on load-use
//             FWD_EN undefined -> no forwarding, stall on any RAW hazard
//                                 against EX or EX/MEM (WB covered by the
//                                 regfile's write-before-read)
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN   = id_ex_stage_pkg::XLEN,
   parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_id_valid,
   input  logic [XLEN-1:0]   i_id_pc,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic [XLEN-1:0]   i_id_rs1_data,
   input  logic [XLEN-1:0]   i_id_rs2_data,
   input  logic [XLEN-1:0]   i_id_imm,
   input  logic [3:0]        i_id_alu_funct,
   input  logic              i_id_src1_pc,
   input  logic              i_id_src2_imm,
   input  logic              i_id_reg_write,
   input  logic              i_id_mem_read,
   input  logic              i_id_mem_write,
   input  logic              i_flush,
   input  logic              i_hold,
   input  logic [REG_AW-1:0] i_exm_rd,
   input  logic              i_exm_reg_write,
   input  logic [XLEN-1:0]   i_exm_result,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_reg_write,
   input  logic [XLEN-1:0]   i_wb_data,
   output logic              o_ex_valid,
   output logic              o_ex_reg_write,
   output logic              o_ex_mem_read,
   output logic              o_ex_mem_write,
   output logic [XLEN-1:0]   o_ex_pc,
   output logic [REG_AW-1:0] o_ex_rd,
   output logic [3:0]        o_alu_funct,
   output logic [XLEN-1:0]   o_alu_op1,
   output logic [XLEN-1:0]   o_alu_op2,
   output logic [XLEN-1:0]   o_ex_store_data,
   output logic              o_id_stall
);

   logic              r_ex_valid, r_ex_reg_write, r_ex_mem_read, r_ex_mem_write;
   logic [XLEN-1:0]   r_ex_pc, r_ex_rs1_data, r_ex_rs2_data, r_ex_imm;
   logic [REG_AW-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
   logic [3:0]        r_alu_funct;
   logic              r_ex_src1_pc, r_ex_src2_imm;

   logic              w_id_reads_ex_rd;
   logic              w_load_use;
   logic              w_raw;
   logic              w_stall;
   logic [XLEN-1:0]   w_fwd_rs1, w_fwd_rs2;

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   assign w_id_reads_ex_rd = (r_ex_rd != '0) &&
                             ((r_ex_rd == i_id_rs1) || (r_ex_rd == i_id_rs2));

   assign w_load_use = i_id_valid & r_ex_valid & r_ex_mem_read & w_id_reads_ex_rd;

`ifdef FWD_EN
   assign w_raw = 1'b0;
`else
   // Without forwarding, any producer still in EX or EX/MEM must drain
   // to WB before the consumer can read the regfile.
   assign w_raw = i_id_valid &
                  ((r_ex_valid & r_ex_reg_write & w_id_reads_ex_rd) |
                   (i_exm_reg_write && (i_exm_rd != '0) &&
                    ((i_exm_rd == i_id_rs1) || (i_exm_rd == i_id_rs2))));
`endif

   // Flush squashes the instruction that would have caused the stall.
   assign w_stall    = (w_load_use | w_raw) & ~i_flush;
   assign o_id_stall = w_stall;

   // ------------------------------------------------------------------
   // ID/EX register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex_valid     <= 1'b0;
         r_ex_reg_write <= 1'b0;
         r_ex_mem_read  <= 1'b0;
         r_ex_mem_write <= 1'b0;
         r_ex_pc        <= '0;
         r_ex_rd        <= '0;
         r_ex_rs1       <= '0;
         r_ex_rs2       <= '0;
         r_ex_rs1_data  <= '0;
         r_ex_rs2_data  <= '0;
         r_ex_imm       <= '0;
         r_alu_funct    <= ALU_ADD;
         r_ex_src1_pc   <= 1'b0;
         r_ex_src2_imm  <= 1'b0;
      end else if (!i_hold) begin
         if (i_flush || w_stall) begin
            r_ex_valid     <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
         end else begin
            r_ex_valid     <= i_id_valid;
            r_ex_reg_write <= i_id_valid & i_id_reg_write;
            r_ex_mem_read  <= i_id_valid & i_id_mem_read;
            r_ex_mem_write <= i_id_valid & i_id_mem_write;
            r_ex_pc        <= i_id_pc;
            r_ex_rd        <= i_id_rd;
            r_ex_rs1       <= i_id_rs1;
            r_ex_rs2       <= i_id_rs2;
            r_ex_rs1_data  <= i_id_rs1_data;
            r_ex_rs2_data  <= i_id_rs2_data;
            r_ex_imm       <= i_id_imm;
            r_alu_funct    <= i_id_alu_funct;
            r_ex_src1_pc   <= i_id_src1_pc;
            r_ex_src2_imm  <= i_id_src2_imm;
         end
      end
   end

   // ------------------------------------------------------------------
   // Forwarding and operand selection
   // ------------------------------------------------------------------
   id_ex_stage_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .i_rs         (r_ex_rs1),
      .i_reg_data   (r_ex_rs1_data),
      .i_exm_rd     (i_exm_rd),
      .i_exm_we     (i_exm_reg_write),
      .i_exm_result (i_exm_result),
      .i_wb_rd      (i_wb_rd),
      .i_wb_we      (i_wb_reg_write),
      .i_wb_data    (i_wb_data),
      .o_data       (w_fwd_rs1)
   );

   id_ex_stage_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .i_rs         (r_ex_rs2),
      .i_reg_data   (r_ex_rs2_data),
      .i_exm_rd     (i_exm_rd),
      .i_exm_we     (i_exm_reg_write),
      .i_exm_result (i_exm_result),
      .i_wb_rd      (i_wb_rd),
      .i_wb_we      (i_wb_reg_write),
      .i_wb_data    (i_wb_data),
      .o_data       (w_fwd_rs2)
   );

   assign o_alu_op1       = r_ex_src1_pc  ? r_ex_pc  : w_fwd_rs1;
   assign o_alu_op2       = r_ex_src2_imm ? r_ex_imm : w_fwd_rs2;
   assign o_ex_store_data = w_fwd_rs2;

   assign o_ex_valid     = r_ex_valid;
   assign o_ex_reg_write = r_ex_reg_write;
   assign o_ex_mem_read  = r_ex_mem_read;
   assign o_ex_mem_write = r_ex_mem_write;
   assign o_ex_pc        = r_ex_pc;
   assign o_ex_rd        = r_ex_rd;
   assign o_alu_funct    = r_alu_funct;

endmodule : id_ex_stage
`default_nettype wire
